// File: rtl/ans_pkg.sv
// ans_pkg: shared definitions for the ANS symbol histogram.
//   SYM_WIDTH / SYM_COUNT : symbol alphabet (4-bit symbols, 16 of them)
//   CNT_WIDTH             : width of a normalized count
//   SHIFT_W               : width of the normalization shift amount
//   state_t               : histogram FSM state encoding
package ans_pkg;

  localparam int SYM_WIDTH = 4;
  localparam int SYM_COUNT = 16;
  localparam int CNT_WIDTH = 4;
  localparam int SHIFT_W   = 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCALE = 2'd1,
    EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/ans_hist_scaler.sv
// ans_hist_scaler: shift selection and per-symbol count normalization.
// Build option: define ANS_HIST_MIN1_EN to force nonzero raw counts that
// would shift down to zero to be emitted as 1.
// Ports:
//   max_raw    - largest raw count of the block
//   shift      - latched shift applied to raw
//   raw        - raw count of the symbol being emitted
//   shift_next - smallest shift bringing max_raw into CNT_WIDTH bits
//   norm       - normalized count for raw
module ans_hist_scaler
  import ans_pkg::*;
#(
  parameter int RAW_W = 8
) (
  input  logic [RAW_W-1:0]     max_raw,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic [RAW_W-1:0]     raw,
  output logic [SHIFT_W-1:0]   shift_next,
  output logic [CNT_WIDTH-1:0] norm
);

  localparam int unsigned      MAX_SHIFT = RAW_W - CNT_WIDTH;
  localparam logic [RAW_W-1:0] CNT_MAX   = RAW_W'((1 << CNT_WIDTH) - 1);

  logic             found;
  logic [RAW_W-1:0] shifted;

  // First (smallest) shift that fits wins; MAX_SHIFT always fits.
  always_comb begin
    shift_next = '0;
    found      = 1'b0;
    for (int unsigned s = 0; s <= MAX_SHIFT; s++) begin
      if (!found && ((max_raw >> s) <= CNT_MAX)) begin
        shift_next = SHIFT_W'(s);
        found      = 1'b1;
      end
    end
  end

  assign shifted = raw >> shift;

  always_comb begin
    norm = CNT_WIDTH'(shifted);
`ifdef ANS_HIST_MIN1_EN
    if ((raw != '0) && (shifted == '0)) begin
      norm = CNT_WIDTH'(1);
    end
`endif
  end

endmodule

// File: rtl/ans_histogram.sv
// ans_histogram: counts 4-bit symbols of a block, then emits the 16
// normalized counts in symbol order for the ANS count loader.
// Build option: ANS_HIST_MIN1_EN (see ans_hist_scaler).
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   in, in_vld, in_last, in_rdy  - symbol input stream (valid/ready)
//   out, out_vld, out_last, out_rdy - normalized count stream (valid/ready)
module ans_histogram
  import ans_pkg::*;
#(
  parameter int RAW_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SYM_WIDTH-1:0] in,
  input  logic                 in_vld,
  input  logic                 in_last,
  output logic                 in_rdy,
  output logic [CNT_WIDTH-1:0] out,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 out_last
);

  localparam logic [SYM_WIDTH-1:0] LAST_IDX = SYM_WIDTH'(SYM_COUNT - 1);

  state_t                 state;
  state_t                 state_next;
  logic [RAW_W-1:0]       raw [SYM_COUNT];
  logic [RAW_W-1:0]       max_raw;
  logic [SHIFT_W-1:0]     shift;
  logic [SHIFT_W-1:0]     shift_next;
  logic [SYM_WIDTH-1:0]   idx;
  logic [RAW_W-1:0]       inc_val;
  logic [RAW_W-1:0]       raw_sel;
  logic [CNT_WIDTH-1:0]   norm;
  logic                   fire_in;
  logic                   fire_out;

  assign fire_in  = in_vld && in_rdy;
  assign fire_out = out_vld && out_rdy;

  // Saturating increment of the addressed counter.
  assign inc_val = (raw[in] == '1) ? raw[in] : raw[in] + RAW_W'(1);
  assign raw_sel = raw[idx];

  ans_hist_scaler #(
    .RAW_W (RAW_W)
  ) u_scaler (
    .max_raw    (max_raw),
    .shift      (shift),
    .raw        (raw_sel),
    .shift_next (shift_next),
    .norm       (norm)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (fire_in && in_last) state_next = SCALE;
      SCALE:   state_next = EMIT;
      EMIT:    if (fire_out && (idx == LAST_IDX)) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Outputs
  always_comb begin
    in_rdy   = (state == ACCUM);
    out_vld  = (state == EMIT);
    out_last = (state == EMIT) && (idx == LAST_IDX);
    out      = (state == EMIT) ? norm : '0;
  end

  // Counters, running maximum, shift and emit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYM_COUNT; i++) begin
        raw[i] <= '0;
      end
      max_raw <= '0;
      shift   <= '0;
      idx     <= '0;
    end else begin
      if (fire_in) begin
        raw[in] <= inc_val;
        if (inc_val > max_raw) begin
          max_raw <= inc_val;
        end
      end
      if (state == SCALE) begin
        shift <= shift_next;
      end
      if (fire_out) begin
        if (idx == LAST_IDX) begin
          for (int unsigned i = 0; i < SYM_COUNT; i++) begin
            raw[i] <= '0;
          end
          max_raw <= '0;
          idx     <= '0;
        end else begin
          idx <= idx + SYM_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ans_histogram.sv
// tb_ans_histogram: directed self-checking bench for ans_histogram.
// Expected normalized counts are hand-computed per block.
module tb_ans_histogram;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic       in_vld;
  logic       in_last;
  logic       in_rdy;
  logic [3:0] out;
  logic       out_vld;
  logic       out_rdy;
  logic       out_last;

  int n_checks;
  int n_pass;

  logic [3:0] exp_cnt [16];

  ans_histogram #(
    .RAW_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .in_vld   (in_vld),
    .in_last  (in_last),
    .in_rdy   (in_rdy),
    .out      (out),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_cnt[i] = 4'd0;
  endtask

  // One symbol transfer; returns 1 time unit after the transfer edge.
  task automatic send(input logic [3:0] sym, input logic last);
    in      = sym;
    in_last = last;
    in_vld  = 1'b1;
    @(posedge clk); #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    while (!out_vld && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_vld_wait", out_vld, 1);
  endtask

  // Sweep the emitted counts against exp_cnt. Optionally stall 5 cycles at
  // stall_at, and stop (without transferring) when reaching stop_at.
  task automatic emit_check(input int stall_at, input int stop_at);
    out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == stop_at) return;
      check($sformatf("vld[%0d]", i), out_vld, 1);
      check($sformatf("out[%0d]", i), out, exp_cnt[i]);
      check($sformatf("last[%0d]", i), out_last, (i == 15) ? 1 : 0);
      if (i == stall_at) begin
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check("stall_out", out, exp_cnt[i]);
          check("stall_last", out_last, 0);
          check("stall_vld", out_vld, 1);
          check("stall_in_rdy", in_rdy, 0);
        end
        out_rdy = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("post_emit_in_rdy", in_rdy, 1);
    check("post_emit_vld", out_vld, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in       = 4'd0;
    in_vld   = 1'b0;
    in_last  = 1'b0;
    out_rdy  = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_vld", out_vld, 0);
    check("rst_last", out_last, 0);
    check("rst_in_rdy", in_rdy, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Block 0,0,3: shift 0, latency check
    send(4'd0, 1'b0);
    send(4'd0, 1'b0);
    send(4'd3, 1'b1);
    check("scale_vld", out_vld, 0);
    check("scale_in_rdy", in_rdy, 0);
    @(posedge clk); #1;
    check("emit_vld_rise", out_vld, 1);
    clear_exp();
    exp_cnt[0] = 4'd2;
    exp_cnt[3] = 4'd1;
    emit_check(-1, 16);

    // Forty 5s, three 9s: max 40 -> shift 2, 40>>2=10, 3>>2=0
    for (int i = 0; i < 40; i++) send(4'd5, 1'b0);
    for (int i = 0; i < 3; i++) send(4'd9, (i == 2));
    wait_vld();
    clear_exp();
    exp_cnt[5] = 4'd10;
`ifdef ANS_HIST_MIN1_EN
    exp_cnt[9] = 4'd1;
`else
    exp_cnt[9] = 4'd0;
`endif
    emit_check(-1, 16);

    // 300 sevens saturate at 255 -> shift 4 -> 15
    for (int i = 0; i < 300; i++) send(4'd7, (i == 299));
    wait_vld();
    clear_exp();
    exp_cnt[7] = 4'd15;
    emit_check(-1, 16);

    // Symbol k sent k times (k=1..15): shift 0, count k; stall at idx 3
    for (int k = 1; k < 16; k++) begin
      for (int j = 0; j < k; j++) send(4'(k), (k == 15) && (j == k - 1));
    end
    wait_vld();
    clear_exp();
    for (int k = 1; k < 16; k++) exp_cnt[k] = 4'(k);
    emit_check(3, 16);

    // Same block, reset at idx 8
    for (int k = 1; k < 16; k++) begin
      for (int j = 0; j < k; j++) send(4'(k), (k == 15) && (j == k - 1));
    end
    wait_vld();
    emit_check(-1, 8);
    check("pre_rst_out8", out, 8);
    rst_n = 1'b0;
    #1;
    check("midrst_vld", out_vld, 0);
    check("midrst_out", out, 0);
    check("midrst_in_rdy", in_rdy, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_vld", out_vld, 0);

    // Single symbol 2 with last
    send(4'd2, 1'b1);
    wait_vld();
    clear_exp();
    exp_cnt[2] = 4'd1;
    emit_check(-1, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
